// File: rtl/mux_scan_avg_pkg.sv
// lock_scan_pkg: scan FSM state encoding, channel count and channel-walk helper
package lock_scan_pkg;
  localparam int NCH = 16;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACC, S_STORE} state_t;
  // Lowest set bit of mask strictly above cur, wrapping to the lowest set bit overall
  function automatic logic [3:0] next_chan(input logic [NCH-1:0] mask, input logic [3:0] cur);
    logic [3:0] lo;
    logic [3:0] hi;
    logic found;
    lo = '0;
    hi = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) lo = 4'(i);
      if (mask[i] && i > int'(cur)) begin
        hi = 4'(i);
        found = 1'b1;
      end
    end
    return found ? hi : lo;
  endfunction
endpackage

// File: rtl/mux_scan_avg_if.sv
// mux_scan_avg_if: muxer select/sample pair plus the per-channel result strobe
interface mux_scan_avg_if #(parameter int RES = 14);
  logic [3:0]     sel;
  logic [RES-1:0] din;
  logic           res_valid;
  logic [3:0]     res_ch;
  logic [RES-1:0] res_data;
  logic           sweep_done;
  modport master (output sel, res_valid, res_ch, res_data, sweep_done, input din);
  modport slave  (input sel, res_valid, res_ch, res_data, sweep_done, output din);
endinterface

// File: rtl/mux_scan_avg_regfile.sv
// scan_regfile: 16-entry result store, one write port, registered read-before-write port
module scan_regfile
  import lock_scan_pkg::*;
#(
  parameter int RES = 14
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           we_i,
  input  logic [3:0]     wa_i,
  input  logic [RES-1:0] wd_i,
  input  logic [3:0]     ra_i,
  output logic [RES-1:0] rd_o
);
  logic [RES-1:0] mem_q [NCH];
  // Read samples the pre-write contents, so a same-edge store shows up one cycle later
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) mem_q[i] <= '0;
      rd_o <= '0;
    end else begin
      rd_o <= mem_q[ra_i];
      if (we_i) mem_q[wa_i] <= wd_i;
    end
endmodule

// File: rtl/mux_scan_avg.sv
// mux_scan_avg: walks masked muxer channels, settles, boxcar-averages and stores per channel
module mux_scan_avg
  import lock_scan_pkg::*;
#(
  parameter int RES      = 14,
  parameter int AVG_LOG2 = 4,
  parameter int SETTLE   = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [NCH-1:0]     chan_mask,
  input  logic [3:0]         rd_ch,
  output logic               busy,
  output logic [RES-1:0]     rd_data,
  mux_scan_avg_if.master     m
);
  localparam int ACCW = RES + AVG_LOG2;
  localparam int CW   = 11;
  state_t                  state_q, state_d;
  logic [3:0]              ch_q, ch_d, nxt, rch_q, rch_d;
  logic [NCH-1:0]          mask_q, mask_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [ACCW-1:0]  acc_q, acc_d, din_x;
  logic [RES-1:0]          rdat_q, rdat_d, res;
  logic                    rv_q, rv_d, sd_q, sd_d, we, wrap, last_settle, last_acc;
  assign din_x       = ACCW'($signed(m.din));
  assign res         = RES'(acc_q >>> AVG_LOG2);
  assign nxt         = next_chan(mask_q, ch_q);
  assign wrap        = nxt <= ch_q;
  assign last_settle = cnt_q == CW'(SETTLE - 1);
  assign last_acc    = cnt_q == CW'((1 << AVG_LOG2) - 1);
  assign busy        = state_q != S_IDLE;
  assign m.sel        = ch_q;
  assign m.res_valid  = rv_q;
  assign m.res_ch     = rch_q;
  assign m.res_data   = rdat_q;
  assign m.sweep_done = sd_q;
  // State, channel, counters, accumulator and result strobe registers
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rv_q    <= 1'b0;
      rch_q   <= '0;
      rdat_q  <= '0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rv_q    <= rv_d;
      rch_q   <= rch_d;
      rdat_q  <= rdat_d;
      sd_q    <= sd_d;
    end
  // Next-state: settle discards samples, acc sums them, store writes and advances the channel
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rv_d    = 1'b0;
    sd_d    = 1'b0;
    rch_d   = rch_q;
    rdat_d  = rdat_q;
    we      = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (chan_mask != '0) begin
          state_d = S_SETTLE;
          mask_d  = chan_mask;
          ch_d    = next_chan(chan_mask, 4'hF);
          cnt_d   = '0;
          acc_d   = '0;
        end
        S_SETTLE: begin
          acc_d   = '0;
          cnt_d   = last_settle ? '0 : cnt_q + 1'b1;
          state_d = last_settle ? S_ACC : S_SETTLE;
        end
        S_ACC: begin
          acc_d   = acc_q + din_x;
          cnt_d   = last_acc ? '0 : cnt_q + 1'b1;
          state_d = last_acc ? S_STORE : S_ACC;
        end
        default: begin
          we      = 1'b1;
          rv_d    = 1'b1;
          rch_d   = ch_q;
          rdat_d  = res;
          sd_d    = wrap;
          cnt_d   = '0;
          mask_d  = wrap ? chan_mask : mask_q;
          ch_d    = !wrap ? nxt : (chan_mask != '0) ? next_chan(chan_mask, 4'hF) : ch_q;
          state_d = (wrap && chan_mask == '0) ? S_IDLE : S_SETTLE;
        end
      endcase
    end
  end
  scan_regfile #(.RES(RES)) u_rf (
    .clk  (clk),
    .rstn (rstn),
    .we_i (we),
    .wa_i (ch_q),
    .wd_i (res),
    .ra_i (rd_ch),
    .rd_o (rd_data)
  );
endmodule

// File: tb/tb_mux_scan_avg.sv
// tb_mux_scan_avg: directed table-driven checks of the channel-scanning averager
module tb_mux_scan_avg;
  logic        clk = 1'b0;
  logic        rstn;
  logic        en_a, en_b, busy_a, busy_b;
  logic [15:0] mask_a, mask_b;
  logic [3:0]  rdch_a, rdch_b;
  logic [15:0] rdd_a;
  logic [13:0] rdd_b;
  logic        mode_a, alt_b;
  int          cval_a, cval_b;
  int          n_cmp = 0, n_bad = 0, cyc, cnt;
  always #5 clk = ~clk;
  mux_scan_avg_if #(.RES(16)) ifa ();
  mux_scan_avg_if #(.RES(14)) ifb ();
  mux_scan_avg #(.RES(16), .AVG_LOG2(4), .SETTLE(2)) dut_a (
    .clk(clk), .rstn(rstn), .en(en_a), .chan_mask(mask_a), .rd_ch(rdch_a),
    .busy(busy_a), .rd_data(rdd_a), .m(ifa));
  mux_scan_avg #(.RES(14), .AVG_LOG2(1), .SETTLE(1)) dut_b (
    .clk(clk), .rstn(rstn), .en(en_b), .chan_mask(mask_b), .rd_ch(rdch_b),
    .busy(busy_b), .rd_data(rdd_b), .m(ifb));
  // Registered muxer models: A is constant or in_i = 1000*i, B is constant or alternating -3/-2
  always @(posedge clk) begin
    ifa.din <= mode_a ? 16'(1000 * ifa.sel) : cval_a[15:0];
    ifb.din <= alt_b ? (($signed(ifb.din) == -14'sd3) ? 14'h3FFE : 14'h3FFD) : cval_b[13:0];
  end
  typedef struct { int ch; int data; bit done; int nsel; } sv_t;
  typedef struct { bit alt; int cval; int exp; } bv_t;
  sv_t tab_a [5];
  bv_t tab_b [5];
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic wait_v(input bit b, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(b ? ifb.res_valid : ifa.res_valid) && c < 200);
    if (!(b ? ifb.res_valid : ifa.res_valid)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut=%0d: no res_valid after %0d cycles", b, c);
    end
  endtask
  initial begin
    tab_a[0] = '{0, 0, 1'b0, 5};
    tab_a[1] = '{5, 5000, 1'b0, 10};
    tab_a[2] = '{10, 10000, 1'b0, 15};
    tab_a[3] = '{15, 15000, 1'b1, 0};
    tab_a[4] = '{0, 0, 1'b0, 5};
    tab_b[0] = '{1'b0, -8192, -8192};
    tab_b[1] = '{1'b0, 8191, 8191};
    tab_b[2] = '{1'b1, 0, -3};
    tab_b[3] = '{1'b0, -1, -1};
    tab_b[4] = '{1'b0, -5, -5};
    rstn = 1'b0; en_a = 1'b0; en_b = 1'b0; mask_a = '0; mask_b = 16'h0001;
    rdch_a = '0; rdch_b = '0; mode_a = 1'b0; alt_b = 1'b0; cval_a = 100; cval_b = 0;
    repeat (3) @(negedge clk);
    chk("rst sel", ifa.sel, 0);
    chk("rst res_valid", ifa.res_valid, 0);
    chk("rst res_ch", ifa.res_ch, 0);
    chk("rst res_data", ifa.res_data, 0);
    chk("rst sweep_done", ifa.sweep_done, 0);
    chk("rst busy", busy_a, 0);
    chk("rst rd_data", rdd_a, 0);
    rstn = 1'b1;
    @(negedge clk);
    mask_a = 16'h0001;
    en_a = 1'b1;
    wait_v(1'b0, cyc);
    chk("c0 first latency", cyc, 20);
    chk("c0 res_ch", ifa.res_ch, 0);
    chk("c0 res_data", $signed(ifa.res_data), 100);
    chk("c0 sweep_done", ifa.sweep_done, 1);
    @(negedge clk);
    chk("c0 strobe width", ifa.res_valid, 0);
    chk("c0 rd_data", rdd_a, 100);
    wait_v(1'b0, cyc);
    chk("c0 period", cyc + 1, 19);
    chk("c0 res_data 2", $signed(ifa.res_data), 100);
    chk("c0 sweep_done 2", ifa.sweep_done, 1);
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    mode_a = 1'b1;
    mask_a = 16'h8421;
    en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_v(1'b0, cyc);
      chk($sformatf("sweep[%0d] res_ch", i), ifa.res_ch, tab_a[i].ch);
      chk($sformatf("sweep[%0d] res_data", i), $signed(ifa.res_data), tab_a[i].data);
      chk($sformatf("sweep[%0d] sweep_done", i), ifa.sweep_done, tab_a[i].done);
      chk($sformatf("sweep[%0d] next sel", i), ifa.sel, tab_a[i].nsel);
    end
    repeat (6) @(negedge clk);
    en_a = 1'b0;
    rdch_a = 4'd5;
    @(negedge clk);
    chk("drop busy", busy_a, 0);
    chk("drop sel hold", ifa.sel, 5);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ifa.res_valid) cnt++;
    end
    chk("drop no res_valid", cnt, 0);
    chk("drop mem5 kept", rdd_a, 5000);
    en_a = 1'b1;
    @(negedge clk);
    chk("restart sel", ifa.sel, 0);
    chk("restart busy", busy_a, 1);
    wait_v(1'b0, cyc);
    chk("restart res_ch", ifa.res_ch, 0);
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    mask_a = 16'h0003;
    rdch_a = 4'd2;
    en_a = 1'b1;
    @(negedge clk);
    mask_a = 16'h0004;
    wait_v(1'b0, cyc);
    chk("mchg ch0", ifa.res_ch, 0);
    chk("mchg ch0 done", ifa.sweep_done, 0);
    wait_v(1'b0, cyc);
    chk("mchg ch1", ifa.res_ch, 1);
    chk("mchg ch1 data", $signed(ifa.res_data), 1000);
    chk("mchg ch1 done", ifa.sweep_done, 1);
    chk("mchg wrap sel", ifa.sel, 2);
    wait_v(1'b0, cyc);
    chk("mchg ch2", ifa.res_ch, 2);
    chk("mchg ch2 done", ifa.sweep_done, 1);
    chk("rd same edge old", rdd_a, 0);
    @(negedge clk);
    chk("rd next edge new", rdd_a, 2000);
    repeat (6) @(negedge clk);
    chk("pre-rst busy", busy_a, 1);
    rstn = 1'b0;
    #1;
    chk("arst sel", ifa.sel, 0);
    chk("arst busy", busy_a, 0);
    chk("arst res_ch", ifa.res_ch, 0);
    chk("arst res_data", ifa.res_data, 0);
    chk("arst rd_data", rdd_a, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post-rst sel", ifa.sel, 2);
    chk("post-rst mem2 cleared", rdd_a, 0);
    wait_v(1'b0, cyc);
    chk("post-rst res_ch", ifa.res_ch, 2);
    chk("post-rst res_data", $signed(ifa.res_data), 2000);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en_b = 1'b0;
      alt_b = tab_b[i].alt;
      cval_b = tab_b[i].cval;
      repeat (3) @(negedge clk);
      en_b = 1'b1;
      wait_v(1'b1, cyc);
      chk($sformatf("b[%0d] res_data", i), $signed(ifb.res_data), tab_b[i].exp);
      chk($sformatf("b[%0d] res_ch", i), ifb.res_ch, 0);
      chk($sformatf("b[%0d] sweep_done", i), ifb.sweep_done, 1);
    end
    wait_v(1'b1, cyc);
    chk("b period", cyc, 4);
    chk("b res_data 2", $signed(ifb.res_data), -5);
    en_b = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
